// File: rtl/switch_in_dev.sv
// Switch input device: two-flop synchroniser, debounce, DATA latch, change counter
// and maskable change interrupt on a four-word bus window.
module switch_in_dev #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int unsigned DW    = 32;
    localparam int unsigned CHG_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;

    logic [DW-1:0]    s1;
    logic [DW-1:0]    s2;
    logic [DW-1:0]    cand;
    logic [DW-1:0]    data_reg;
    logic [CNT_W-1:0] cnt;
    logic             ie;
    logic             pending;
    logic [CHG_W-1:0] chg_cnt;

    logic stable;
    logic commit;
    logic wr_ctrl;
    logic clr_pend;
    logic unused_wdata;

    // A commit only happens on the edge the candidate completes its hold and differs from DATA.
    assign stable   = (s2 == cand) && (cnt == CNT_MAX);
    assign commit   = stable && (cand != data_reg);
    assign wr_ctrl  = we && (addr == A_CTRL);
    assign clr_pend = we && (addr == A_STATUS) && wdata[0];
    assign unused_wdata = ^wdata[DW-1:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            cand     <= '0;
            data_reg <= '0;
            cnt      <= '0;
            ie       <= 1'b0;
            pending  <= 1'b0;
            chg_cnt  <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;

            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (commit) begin
                data_reg <= cand;
                chg_cnt  <= chg_cnt + CHG_W'(1);
            end

            // Set beats clear; commit sees the pre-write ie.
            if (commit && ie) begin
                pending <= 1'b1;
            end else if (clr_pend) begin
                pending <= 1'b0;
            end

            if (wr_ctrl) begin
                ie <= wdata[0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            A_DATA:   rdata = data_reg;
            A_CTRL:   rdata = {31'b0, ie};
            A_STATUS: rdata = {16'b0, chg_cnt, 7'b0, pending};
            default:  rdata = '0;
        endcase
    end

    assign irq = pending & ie;

endmodule
